// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: scans NR_ENTRIES PMP entries LANES at a time and
// reports the lowest-indexed matching entry's verdict over a valid/ready response.
module pmp_seq_checker #(
  parameter int unsigned PLEN       = 56,
  parameter int unsigned PMP_LEN    = 54,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned LANES      = 4,
  parameter int unsigned IDX_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_valid_i,
  output logic                          req_ready_o,
  input  logic [PLEN-1:0]               req_addr_i,
  input  logic [1:0]                    req_access_i,
  input  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i,
  input  logic [NR_ENTRIES*8-1:0]       conf_cfg_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic                          rsp_allow_o,
  output logic                          rsp_match_o,
  output logic [IDX_W-1:0]              rsp_idx_o
);

  localparam int unsigned NR_GROUPS = NR_ENTRIES / LANES;
  localparam int unsigned GRP_W     = (NR_GROUPS > 1) ? $clog2(NR_GROUPS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_e;

  state_e            state_q, state_d;
  logic [PLEN-1:0]   addr_q, addr_d;
  logic [1:0]        access_q, access_d;
  logic [GRP_W-1:0]  g_q, g_d;
  logic              allow_q, allow_d;
  logic              match_q, match_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  function automatic logic [PLEN-1:0] pmp_ext(input logic [PMP_LEN-1:0] a);
    return PLEN'(a) << 2;
  endfunction

  function automatic logic entry_match(input logic [PLEN-1:0]    addr,
                                       input logic [1:0]         mode,
                                       input logic [PMP_LEN-1:0] cur,
                                       input logic [PMP_LEN-1:0] prev,
                                       input logic               first);
    logic [PLEN-1:0]    cur_e, prev_e, mask;
    logic [PMP_LEN-1:0] ones;
    logic               m;
    cur_e  = pmp_ext(cur);
    prev_e = first ? '0 : pmp_ext(prev);
    // cur ^ (cur+1) sets the trailing-ones run plus one bit; with the two
    // implicit address LSBs this spans exactly the NAPOT region size.
    ones   = cur ^ (cur + PMP_LEN'(1));
    mask   = ~((PLEN'(ones) << 2) | PLEN'(3));
    case (mode)
      2'd1:    m = (prev_e < cur_e) && (addr >= prev_e) && (addr < cur_e);
      2'd2:    m = ({addr[PLEN-1:2], 2'b00} == cur_e);
      2'd3:    m = ((addr & mask) == (cur_e & mask));
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic perm_ok(input logic [1:0] access, input logic r, input logic w);
    return (~access[0] | r) & (~access[1] | w);
  endfunction

  always_comb begin
    logic hit, hit_allow;
    int   hit_idx, e, pe;
    state_d   = state_q;
    addr_d    = addr_q;
    access_d  = access_q;
    g_d       = g_q;
    allow_d   = allow_q;
    match_d   = match_q;
    idx_d     = idx_q;
    hit       = 1'b0;
    hit_allow = 1'b0;
    hit_idx   = 0;
    e         = 0;
    pe        = 0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d   = req_addr_i;
          access_d = req_access_i;
          g_d      = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        // Walk lanes high to low so the lowest matching index wins.
        for (int l = int'(LANES) - 1; l >= 0; l--) begin
          e  = int'(g_q) * int'(LANES) + l;
          pe = (e == 0) ? 0 : e - 1;
          if (entry_match(addr_q, conf_cfg_i[e*8+3 +: 2],
                          conf_addr_i[e*PMP_LEN +: PMP_LEN],
                          conf_addr_i[pe*PMP_LEN +: PMP_LEN], e == 0)) begin
            hit       = 1'b1;
            hit_idx   = e;
            hit_allow = perm_ok(access_q, conf_cfg_i[e*8], conf_cfg_i[e*8+1]);
          end
        end
        if (hit) begin
          match_d = 1'b1;
          idx_d   = IDX_W'(hit_idx);
          allow_d = hit_allow;
          state_d = RESP;
        end else if (g_q == GRP_W'(NR_GROUPS - 1)) begin
          match_d = 1'b0;
          idx_d   = '0;
          allow_d = 1'b0;
          state_d = RESP;
        end else begin
          g_d = g_q + GRP_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      access_q <= '0;
      g_q      <= '0;
      allow_q  <= 1'b0;
      match_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      access_q <= access_d;
      g_q      <= g_d;
      allow_q  <= allow_d;
      match_q  <= match_d;
      idx_q    <= idx_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_allow_o = allow_q;
  assign rsp_match_o = match_q;
  assign rsp_idx_o   = idx_q;

endmodule

// File: tb/tb_pmp_seq_checker.sv
// Directed bench for pmp_seq_checker: NAPOT/TOR/NA4 matching, priority,
// latency, backpressure and asynchronous reset during a scan.
module tb_pmp_seq_checker;

  localparam int PLEN = 56, PMP_LEN = 54, NR_ENTRIES = 16, LANES = 4, IDX_W = 4;

  logic                          clk = 1'b0;
  logic                          rst_ni;
  logic                          req_valid_i;
  logic                          req_ready_o;
  logic [PLEN-1:0]               req_addr_i;
  logic [1:0]                    req_access_i;
  logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_i;
  logic [NR_ENTRIES*8-1:0]       conf_cfg_i;
  logic                          rsp_valid_o;
  logic                          rsp_ready_i;
  logic                          rsp_allow_o;
  logic                          rsp_match_o;
  logic [IDX_W-1:0]              rsp_idx_o;

  int n_err = 0;
  int n_chk = 0;

  pmp_seq_checker #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR_ENTRIES), .LANES(LANES)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_access_i(req_access_i),
    .conf_addr_i(conf_addr_i), .conf_cfg_i(conf_cfg_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_allow_o(rsp_allow_o), .rsp_match_o(rsp_match_o), .rsp_idx_o(rsp_idx_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_cfg();
    conf_addr_i = '0;
    conf_cfg_i  = '0;
  endtask

  task automatic set_entry(input int i, input logic [PMP_LEN-1:0] a, input logic [7:0] c);
    conf_addr_i[i*PMP_LEN +: PMP_LEN] = a;
    conf_cfg_i[i*8 +: 8]              = c;
  endtask

  // Handshake in cycle 0; returns #1 after that edge (cycle 1).
  task automatic issue(input string tag, input logic [PLEN-1:0] a, input logic [1:0] acc);
    @(negedge clk);
    check({tag, ".rdy"}, req_ready_o, 1'b1);
    req_valid_i  = 1'b1;
    req_addr_i   = a;
    req_access_i = acc;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid_o && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
    check({tag, ".rdy_after"}, req_ready_o, 1'b1);
    check({tag, ".vld_after"}, rsp_valid_o, 1'b0);
  endtask

  task automatic run(input string tag, input logic [PLEN-1:0] a, input logic [1:0] acc,
                     input logic e_allow, input logic e_match, input int e_idx, input int e_lat);
    int n;
    issue(tag, a, acc);
    wait_rsp(n);
    check({tag, ".lat"}, 64'(n), 64'(e_lat));
    check({tag, ".match"}, rsp_match_o, e_match);
    check({tag, ".allow"}, rsp_allow_o, e_allow);
    check({tag, ".idx"}, 64'(rsp_idx_o), 64'(e_idx));
    ack(tag);
  endtask

  initial begin
    int n, seen;
    logic a0, m0;
    logic [IDX_W-1:0] i0;
    rst_ni       = 1'b0;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_access_i = '0;
    rsp_ready_i  = 1'b0;
    clear_cfg();
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", req_ready_o, 1'b1);
    check("rst.rsp_valid", rsp_valid_o, 1'b0);
    check("rst.allow", rsp_allow_o, 1'b0);
    check("rst.match", rsp_match_o, 1'b0);
    check("rst.idx", 64'(rsp_idx_o), 64'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // NAPOT 4 KiB at 0x8000_0000 on entry 5, read-only
    set_entry(5, 54'h2000_01FF, 8'h19);
    run("napot_hit",  56'h8000_0FFC, 2'b01, 1'b1, 1'b1, 5, 3);
    run("napot_miss", 56'h8000_1000, 2'b01, 1'b0, 1'b0, 0, 5);
    run("napot_low",  56'h7FFF_FFFC, 2'b01, 1'b0, 1'b0, 0, 5);
    run("napot_wr",   56'h8000_0000, 2'b10, 1'b0, 1'b1, 5, 3);

    // Priority: entry 2 R-only beats entry 9 RW over the same region
    clear_cfg();
    set_entry(2, 54'h2000_01FF, 8'h19);
    set_entry(9, 54'h2000_01FF, 8'h1B);
    run("prio_wr",   56'h8000_0010, 2'b10, 1'b0, 1'b1, 2, 2);
    run("prio_none", 56'h8000_0010, 2'b00, 1'b1, 1'b1, 2, 2);

    // TOR on entry 0 covers [0, 0x1000)
    clear_cfg();
    set_entry(0, 54'h400, 8'h0B);
    run("tor0_hit",  56'hFFF,  2'b01, 1'b1, 1'b1, 0, 2);
    run("tor0_miss", 56'h1000, 2'b01, 1'b0, 1'b0, 0, 5);
    // Entry 3 TOR with prev 0x500 >= cur 0x400 never matches
    set_entry(2, 54'h500, 8'h00);
    set_entry(3, 54'h400, 8'h0B);
    run("tor3_inv", 56'h1200, 2'b01, 1'b0, 1'b0, 0, 5);
    set_entry(0, 54'h0, 8'h00);
    run("tor3_inv_lo", 56'h800, 2'b01, 1'b0, 1'b0, 0, 5);
    // Entry 3 TOR [0x1400, 0x1800)
    set_entry(3, 54'h600, 8'h0B);
    run("tor3_lo",   56'h1400, 2'b11, 1'b1, 1'b1, 3, 2);
    run("tor3_below", 56'h13FC, 2'b01, 1'b0, 1'b0, 0, 5);
    run("tor3_top",  56'h1800, 2'b01, 1'b0, 1'b0, 0, 5);

    // NA4 on the last entry
    clear_cfg();
    set_entry(15, 54'h100, 8'h11);
    run("na4_a", 56'h400, 2'b01, 1'b1, 1'b1, 15, 5);
    run("na4_b", 56'h403, 2'b01, 1'b1, 1'b1, 15, 5);
    run("na4_wr", 56'h400, 2'b10, 1'b0, 1'b1, 15, 5);
    run("na4_miss", 56'h404, 2'b01, 1'b0, 1'b0, 0, 5);

    // Backpressure with a persistent, changing request
    clear_cfg();
    set_entry(5, 54'h2000_01FF, 8'h19);
    issue("bp", 56'h8000_0100, 2'b01);
    req_valid_i = 1'b1;
    wait_rsp(n);
    check("bp.lat", 64'(n), 64'd3);
    a0 = rsp_allow_o;
    m0 = rsp_match_o;
    i0 = rsp_idx_o;
    check("bp.match", m0, 1'b1);
    check("bp.allow", a0, 1'b1);
    check("bp.idx", 64'(i0), 64'd5);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_addr_i = 56'h1000 * (c + 1);
      @(posedge clk);
      #1;
      check("bp.vld", rsp_valid_o, 1'b1);
      check("bp.rdy", req_ready_o, 1'b0);
      check("bp.allow_hold", rsp_allow_o, a0);
      check("bp.match_hold", rsp_match_o, m0);
      check("bp.idx_hold", 64'(rsp_idx_o), 64'(i0));
    end
    @(negedge clk);
    req_valid_i = 1'b0;
    ack("bp");
    run("bp_next", 56'h8000_0FFC, 2'b10, 1'b0, 1'b1, 5, 3);

    // Async reset one cycle into a no-match scan
    run("pre_rst", 56'h8000_0004, 2'b01, 1'b1, 1'b1, 5, 3);
    clear_cfg();
    issue("rst_scan", 56'h8000_0004, 2'b01);
    rst_ni = 1'b0;
    #1;
    check("rst_scan.vld", rsp_valid_o, 1'b0);
    check("rst_scan.rdy", req_ready_o, 1'b1);
    check("rst_scan.match", rsp_match_o, 1'b0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o) seen++;
    end
    check("rst_scan.no_rsp", 64'(seen), 64'd0);
    check("rst_scan.idle_rdy", req_ready_o, 1'b1);
    set_entry(5, 54'h2000_01FF, 8'h19);
    run("post_rst", 56'h8000_0FFC, 2'b01, 1'b1, 1'b1, 5, 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
